// File: rtl/spi_frame_receiver_if.sv
// Byte-level SPI master core handshake plus the local SRAM write port.
// The receiver drives through "master"; the core and SRAM sit on "slave".
interface spi_frame_receiver_if;
    logic        di_req;
    logic        wr_ack;
    logic        do_valid;
    logic [7:0]  spi_data_in;
    logic [7:0]  spi_data_out;
    logic        wren;
    logic        sram_ready;
    logic [15:0] sram_addr;
    logic [15:0] sram_data;
    logic        sram_start;
    logic        sram_rw;

    modport master (
        input  di_req, wr_ack, do_valid, spi_data_in, sram_ready,
        output spi_data_out, wren, sram_addr, sram_data, sram_start, sram_rw
    );

    modport slave (
        output di_req, wr_ack, do_valid, spi_data_in, sram_ready,
        input  spi_data_out, wren, sram_addr, sram_data, sram_start, sram_rw
    );
endinterface

// File: rtl/spi_frame_receiver.sv
// Fetches one frame over a byte-level SPI master core: size query, then data
// query, reassembling little-endian 16-bit pixels into SRAM addresses 0..stop_addr.
module spi_frame_receiver #(
    parameter logic [7:0]  CMD_SIZE = 8'h7F,
    parameter logic [7:0]  CMD_DATA = 8'hBF,
    parameter logic [7:0]  DUMMY    = 8'h00,
    parameter logic [15:0] MAX_STOP = 16'h7F7F
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    spi_frame_receiver_if.master        bus,
    output logic [15:0]                 stop_addr,
    output logic                        busy,
    output logic                        done,
    output logic                        size_err
);

    typedef enum logic [3:0] {
        StIdle,
        StCmdS,
        StSize0,
        StSize1,
        StSize2,
        StCmdD,
        StPixLo,
        StPixHi,
        StWr,
        StWrWait,
        StDone
    } state_t;

    typedef enum logic [1:0] {
        BReq,
        BAck,
        BRx
    } byte_state_t;

    state_t      state;
    byte_state_t bstate;
    logic [6:0]  b0;
    logic [6:0]  b1;
    logic        wr_settle;

    logic        xfer;
    logic [7:0]  tx_byte;
    logic        byte_done;
    logic [15:0] decoded;

    // Which top states run the byte primitive, and what each one transmits.
    always_comb begin
        xfer    = 1'b0;
        tx_byte = DUMMY;
        case (state)
            StCmdS: begin
                xfer    = 1'b1;
                tx_byte = CMD_SIZE;
            end
            StCmdD: begin
                xfer    = 1'b1;
                tx_byte = CMD_DATA;
            end
            StSize0, StSize1, StSize2, StPixLo, StPixHi: xfer = 1'b1;
            default: ;
        endcase
    end

    assign byte_done = xfer && (bstate == BRx) && bus.do_valid;

    // Size bytes carry 7 payload bits each in [7:1]; bit 0 is discarded.
    assign decoded = {1'b0, b0, 1'b0, b1};

    assign bus.sram_rw = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= StIdle;
            bstate           <= BReq;
            b0               <= '0;
            b1               <= '0;
            wr_settle        <= 1'b0;
            bus.spi_data_out <= '0;
            bus.wren         <= 1'b0;
            bus.sram_addr    <= '0;
            bus.sram_data    <= '0;
            bus.sram_start   <= 1'b1;
            stop_addr        <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            size_err         <= 1'b0;
        end else begin
            done           <= 1'b0;
            bus.sram_start <= 1'b1;

            // wr_ack is only looked at once the byte is loaded, so a wr_ack
            // coincident with di_req is ignored.
            if (xfer) begin
                case (bstate)
                    BReq: if (bus.di_req) begin
                        bus.spi_data_out <= tx_byte;
                        bus.wren         <= 1'b1;
                        bstate           <= BAck;
                    end
                    BAck: if (bus.wr_ack) begin
                        bus.wren <= 1'b0;
                        bstate   <= BRx;
                    end
                    BRx: if (bus.do_valid) begin
                        bstate <= BReq;
                    end
                    default: bstate <= BReq;
                endcase
            end

            case (state)
                StIdle: if (start) begin
                    busy     <= 1'b1;
                    size_err <= 1'b0;
                    state    <= StCmdS;
                end
                StCmdS: if (byte_done) begin
                    state <= StSize0;
                end
                StSize0: if (byte_done) begin
                    b0    <= bus.spi_data_in[7:1];
                    state <= StSize1;
                end
                StSize1: if (byte_done) begin
                    b1    <= bus.spi_data_in[7:1];
                    state <= StSize2;
                end
                StSize2: if (byte_done) begin
                    if (decoded > MAX_STOP) begin
                        stop_addr <= MAX_STOP;
                        size_err  <= 1'b1;
                    end else begin
                        stop_addr <= decoded;
                    end
                    if (bus.spi_data_in != 8'h00) begin
                        size_err <= 1'b1;
                    end
                    state <= StCmdD;
                end
                StCmdD: begin
                    bus.sram_addr <= '0;
                    if (byte_done) begin
                        state <= StPixLo;
                    end
                end
                StPixLo: if (byte_done) begin
                    bus.sram_data[7:0] <= bus.spi_data_in;
                    state              <= StPixHi;
                end
                StPixHi: if (byte_done) begin
                    bus.sram_data[15:8] <= bus.spi_data_in;
                    state               <= StWr;
                end
                StWr: if (bus.sram_ready) begin
                    bus.sram_start <= 1'b0;
                    wr_settle      <= 1'b1;
                    state          <= StWrWait;
                end
                StWrWait: begin
                    // First cycle after the strobe: sram_ready still reflects
                    // the previous idle state, so it is not trusted yet.
                    if (wr_settle) begin
                        wr_settle <= 1'b0;
                    end else if (bus.sram_ready) begin
                        if (bus.sram_addr == stop_addr) begin
                            state <= StDone;
                        end else begin
                            bus.sram_addr <= bus.sram_addr + 16'd1;
                            state         <= StPixLo;
                        end
                    end
                end
                StDone: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Bench for spi_frame_receiver: behavioural SPI core and SRAM models with a
// scoreboard of expected SRAM writes filled as response bytes are queued.
module tb_spi_frame_receiver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] stop_addr;
    logic        busy;
    logic        done;
    logic        size_err;

    spi_frame_receiver_if bus ();

    spi_frame_receiver dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .stop_addr (stop_addr),
        .busy      (busy),
        .done      (done),
        .size_err  (size_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  tx_log[$];
    logic [15:0] exp_addr_q[$];
    logic [15:0] exp_data_q[$];
    logic [15:0] words[$];

    int hold_cfg  = 0;
    int ack_cfg   = 0;
    int sram_lat  = 2;
    int link_viol = 0;
    int bp_viol   = 0;
    int pulses    = 0;
    int done_cnt  = 0;

    // SPI master core model, driven on the falling edge.
    initial begin
        int         phase;
        int         hold_cnt;
        int         ack_cnt;
        logic [7:0] cur_tx;
        phase = 0; hold_cnt = 0; ack_cnt = 0; cur_tx = 8'h00;
        bus.di_req = 1'b0; bus.wr_ack = 1'b0; bus.do_valid = 1'b0; bus.spi_data_in = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                phase = 0; hold_cnt = hold_cfg;
                bus.di_req = 1'b0; bus.wr_ack = 1'b0; bus.do_valid = 1'b0;
            end else begin
                case (phase)
                    0: begin
                        if (bus.wren) begin
                            if (!bus.di_req) link_viol++;
                            cur_tx = bus.spi_data_out;
                            tx_log.push_back(cur_tx);
                            bus.di_req = 1'b0;
                            ack_cnt = ack_cfg;
                            phase = 1;
                        end else if (hold_cnt > 0) begin
                            bus.di_req = 1'b0;
                            hold_cnt--;
                        end else begin
                            bus.di_req = 1'b1;
                        end
                    end
                    1: begin
                        if (!bus.wren || bus.spi_data_out !== cur_tx) link_viol++;
                        if (ack_cnt > 0) ack_cnt--;
                        else begin
                            bus.wr_ack = 1'b1;
                            phase = 2;
                        end
                    end
                    2: begin
                        bus.wr_ack = 1'b0;
                        bus.do_valid = 1'b1;
                        bus.spi_data_in = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
                        phase = 3;
                    end
                    default: begin
                        bus.do_valid = 1'b0;
                        hold_cnt = hold_cfg;
                        phase = 0;
                    end
                endcase
            end
        end
    end

    // SRAM model and write scoreboard.
    initial begin
        int          busy_cnt;
        logic [15:0] last_addr;
        logic [15:0] last_data;
        logic [15:0] ea;
        logic [15:0] ed;
        busy_cnt = 0; last_addr = '0; last_data = '0;
        bus.sram_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (!reset) begin
                bus.sram_ready = 1'b1;
                busy_cnt = 0;
            end else if (busy_cnt > 0) begin
                if (bus.wren || !bus.sram_start) bp_viol++;
                if (bus.sram_addr !== last_addr || bus.sram_data !== last_data) bp_viol++;
                busy_cnt--;
                if (busy_cnt == 0) bus.sram_ready = 1'b1;
            end else if (!bus.sram_start) begin
                pulses++;
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL sram_write: got write addr %h data %h, expected no write",
                             bus.sram_addr, bus.sram_data);
                end else begin
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    if (bus.sram_addr !== ea || bus.sram_data !== ed) begin
                        errors++;
                        $display("FAIL sram_write: got addr %h data %h, expected addr %h data %h",
                                 bus.sram_addr, bus.sram_data, ea, ed);
                    end
                end
                last_addr = bus.sram_addr;
                last_data = bus.sram_data;
                bus.sram_ready = 1'b0;
                busy_cnt = sram_lat;
            end
        end
    end

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Response bytes: junk for CMD_S, b0..b2, junk for CMD_D, then pixels low byte first.
    task automatic queue_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        rx_q.push_back(8'hA5);
        rx_q.push_back(b0);
        rx_q.push_back(b1);
        rx_q.push_back(b2);
        rx_q.push_back(8'h5A);
        for (int i = 0; i < words.size(); i++) begin
            rx_q.push_back(words[i][7:0]);
            rx_q.push_back(words[i][15:8]);
            exp_addr_q.push_back(16'(i));
            exp_data_q.push_back(words[i]);
        end
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.spi_data_out, bus.wren} !== 9'h000) begin
            errors++;
            $display("FAIL reset_spi: got data %h wren %b, expected 00 0", bus.spi_data_out, bus.wren);
        end
        checks++;
        if ({bus.sram_addr, bus.sram_data} !== 32'h0) begin
            errors++;
            $display("FAIL reset_sram_bus: got addr %h data %h, expected 0000 0000",
                     bus.sram_addr, bus.sram_data);
        end
        checks++;
        if ({bus.sram_start, bus.sram_rw} !== 2'b10) begin
            errors++;
            $display("FAIL reset_sram_ctl: got start %b rw %b, expected 1 0", bus.sram_start, bus.sram_rw);
        end
        checks++;
        if ({stop_addr, busy, done, size_err} !== 19'h0) begin
            errors++;
            $display("FAIL reset_status: got stop %h busy %b done %b err %b, expected 0000 0 0 0",
                     stop_addr, busy, done, size_err);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_size_decode;
        bit         seen;
        int         bad;
        logic [7:0] hdr[5];
        hdr = '{8'h7F, 8'h00, 8'h00, 8'h00, 8'hBF};
        rx_q.delete(); tx_log.delete(); words.delete();
        for (int i = 0; i < 261; i++) words.push_back(16'(i * 16'h0123 + 16'h0F0F));
        queue_frame(8'h02, 8'h08, 8'h00);
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL decode_busy: got %b, expected 1", busy);
        end
        wait_done(20000, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL decode_done: got no done pulse, expected one");
        end
        checks++;
        if (stop_addr !== 16'h0104 || size_err !== 1'b0) begin
            errors++;
            $display("FAIL decode_stop: got stop %h err %b, expected 0104 0", stop_addr, size_err);
        end
        checks++;
        if (tx_log.size() !== 527) begin
            errors++;
            $display("FAIL decode_tx_count: got %0d, expected 527", tx_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (tx_log[i] !== hdr[i]) begin
                    errors++;
                    $display("FAIL decode_tx_byte%0d: got %h, expected %h", i, tx_log[i], hdr[i]);
                end
            end
            bad = 0;
            for (int i = 5; i < 527; i++) if (tx_log[i] !== 8'h00) bad++;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL decode_tx_dummy: got %0d non-dummy bytes, expected 0", bad);
            end
        end
        checks++;
        if (exp_addr_q.size() !== 0) begin
            errors++;
            $display("FAIL decode_writes: got %0d writes missing, expected 0", exp_addr_q.size());
        end
    endtask

    task automatic test_small_frame;
        bit seen;
        int p0;
        int d0;
        rx_q.delete(); words.delete();
        words.push_back(16'h1234); words.push_back(16'h5678); words.push_back(16'h9ABC);
        queue_frame(8'h00, 8'h04, 8'h00);
        p0 = pulses;
        d0 = done_cnt;
        pulse_start();
        wait_done(2000, seen);
        checks++;
        if (!seen || pulses - p0 !== 3) begin
            errors++;
            $display("FAIL small_pulses_at_done: got done %b after %0d pulses, expected 1 after 3",
                     seen, pulses - p0);
        end
        checks++;
        if (busy !== 1'b0 || bus.sram_addr !== 16'h0002) begin
            errors++;
            $display("FAIL small_end_state: got busy %b addr %h, expected 0 0002", busy, bus.sram_addr);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1 || pulses - p0 !== 3) begin
            errors++;
            $display("FAIL small_counts: got %0d done %0d pulses, expected 1 and 3",
                     done_cnt - d0, pulses - p0);
        end
        checks++;
        if (exp_addr_q.size() !== 0) begin
            errors++;
            $display("FAIL small_writes: got %0d writes missing, expected 0", exp_addr_q.size());
        end
    endtask

    task automatic test_handshake_stall;
        bit         seen;
        logic [7:0] seq[7];
        seq = '{8'h7F, 8'h00, 8'h00, 8'h00, 8'hBF, 8'h00, 8'h00};
        rx_q.delete(); tx_log.delete(); words.delete();
        words.push_back(16'hBEEF);
        queue_frame(8'h00, 8'h01, 8'h00);
        hold_cfg = 20; ack_cfg = 5; link_viol = 0;
        pulse_start();
        wait_done(3000, seen);
        hold_cfg = 0; ack_cfg = 0;
        checks++;
        if (!seen || link_viol !== 0) begin
            errors++;
            $display("FAIL stall_handshake: got done %b violations %0d, expected 1 0", seen, link_viol);
        end
        checks++;
        if (tx_log.size() !== 7) begin
            errors++;
            $display("FAIL stall_tx_count: got %0d, expected 7", tx_log.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (tx_log[i] !== seq[i]) begin
                    errors++;
                    $display("FAIL stall_tx_byte%0d: got %h, expected %h", i, tx_log[i], seq[i]);
                end
            end
        end
        checks++;
        if (exp_addr_q.size() !== 0 || stop_addr !== 16'h0000) begin
            errors++;
            $display("FAIL stall_writes: got %0d missing stop %h, expected 0 0000",
                     exp_addr_q.size(), stop_addr);
        end
    endtask

    task automatic test_sram_backpressure;
        bit seen;
        int p0;
        rx_q.delete(); words.delete();
        words.push_back(16'hA1B2); words.push_back(16'hC3D4);
        queue_frame(8'h00, 8'h02, 8'h00);
        sram_lat = 10; bp_viol = 0;
        p0 = pulses;
        pulse_start();
        repeat (30) @(negedge clk);
        pulse_start();  // ignored while busy
        wait_done(3000, seen);
        sram_lat = 2;
        checks++;
        if (!seen || bp_viol !== 0) begin
            errors++;
            $display("FAIL backpressure: got done %b violations %0d, expected 1 0", seen, bp_viol);
        end
        checks++;
        if (pulses - p0 !== 2 || exp_addr_q.size() !== 0 || stop_addr !== 16'h0001) begin
            errors++;
            $display("FAIL backpressure_writes: got %0d pulses %0d missing stop %h, expected 2 0 0001",
                     pulses - p0, exp_addr_q.size(), stop_addr);
        end
    endtask

    task automatic test_size_error;
        bit seen;
        rx_q.delete(); words.delete();
        words.push_back(16'h0042); words.push_back(16'h0043);
        queue_frame(8'h00, 8'h02, 8'h55);
        pulse_start();
        wait_done(2000, seen);
        repeat (4) @(negedge clk);
        checks++;
        if (!seen || size_err !== 1'b1 || stop_addr !== 16'h0001) begin
            errors++;
            $display("FAIL size_err_set: got done %b err %b stop %h, expected 1 1 0001",
                     seen, size_err, stop_addr);
        end
        checks++;
        if (exp_addr_q.size() !== 0) begin
            errors++;
            $display("FAIL size_err_writes: got %0d missing, expected 0", exp_addr_q.size());
        end
        words.delete();
        words.push_back(16'h7777);
        queue_frame(8'h00, 8'h00, 8'h00);
        pulse_start();
        checks++;
        if (size_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL size_err_clear: got err %b busy %b, expected 0 1", size_err, busy);
        end
        wait_done(2000, seen);
        checks++;
        if (!seen || size_err !== 1'b0 || exp_addr_q.size() !== 0) begin
            errors++;
            $display("FAIL size_err_clean_run: got done %b err %b missing %0d, expected 1 0 0",
                     seen, size_err, exp_addr_q.size());
        end
    endtask

    task automatic test_reset_mid_frame;
        bit seen;
        int p0;
        rx_q.delete(); tx_log.delete(); words.delete();
        for (int i = 0; i < 8; i++) words.push_back(16'(16'hC000 + i * 16'h0111));
        queue_frame(8'h00, 8'h0E, 8'h00);
        p0 = pulses;
        pulse_start();
        seen = 1'b0;
        // Byte index 16 is the high byte of word 5.
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (tx_log.size() >= 17) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midreset_reach: got %0d tx bytes, expected 17", tx_log.size());
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (bus.wren !== 1'b0 || bus.sram_start !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got wren %b start %b busy %b, expected 0 1 0",
                     bus.wren, bus.sram_start, busy);
        end
        @(negedge clk);
        checks++;
        if ({bus.sram_addr, bus.sram_data, stop_addr, bus.spi_data_out} !== 56'h0) begin
            errors++;
            $display("FAIL midreset_regs: got addr %h data %h stop %h tx %h, expected all zero",
                     bus.sram_addr, bus.sram_data, stop_addr, bus.spi_data_out);
        end
        checks++;
        if (pulses - p0 !== 5) begin
            errors++;
            $display("FAIL midreset_pulses: got %0d, expected 5", pulses - p0);
        end
        rx_q.delete(); exp_addr_q.delete(); exp_data_q.delete(); words.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        words.push_back(16'h1111); words.push_back(16'h2222); words.push_back(16'h3333);
        queue_frame(8'h00, 8'h04, 8'h00);
        p0 = pulses;
        pulse_start();
        wait_done(2000, seen);
        checks++;
        if (!seen || pulses - p0 !== 3 || exp_addr_q.size() !== 0) begin
            errors++;
            $display("FAIL midreset_refetch: got done %b pulses %0d missing %0d, expected 1 3 0",
                     seen, pulses - p0, exp_addr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_size_decode();
        test_small_frame();
        test_handshake_stall();
        test_sram_backpressure();
        test_size_error();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
